// File: rtl/bullet_sched_pkg.sv
// Shared types and constants for the two-player bullet slot scheduler.
// Slot lifecycle, player identity and facing direction live here so every file agrees on encodings.
package bullet_sched_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        LAUNCH = 2'd1,
        ARM    = 2'd2,
        FLIGHT = 2'd3
    } slot_state_t;

    typedef enum logic {
        PLAYER1 = 1'b0,
        PLAYER2 = 1'b1
    } player_t;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        UP    = 2'd3
    } dir_t;

    localparam logic [7:0] DEF_P1_FIRE_KEY = 8'd44;
    localparam logic [7:0] DEF_P2_FIRE_KEY = 8'd88;

    function automatic player_t other_player(input player_t p);
        return (p == PLAYER1) ? PLAYER2 : PLAYER1;
    endfunction

endpackage

// File: rtl/bullet_slot_fsm.sv
// One bullet slot: FREE -> LAUNCH -> ARM -> FLIGHT -> FREE occupancy tracker.
// Owner and direction are captured on grant and held until the slot is granted again.
module bullet_slot_fsm
    import bullet_sched_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_grant,
    input  player_t     i_grant_owner,
    input  dir_t        i_grant_dir,
    input  logic        i_slot_busy,
    output logic        o_launch,
    output slot_state_t o_state,
    output player_t     o_owner,
    output dir_t        o_dir
);

    slot_state_t r_state;
    slot_state_t w_next;
    logic        r_arm_cnt;
    logic        w_arm_cnt_next;
    player_t     r_owner;
    dir_t        r_dir;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= FREE;
            r_arm_cnt <= 1'b0;
            r_owner   <= PLAYER1;
            r_dir     <= LEFT;
        end else begin
            r_state   <= w_next;
            r_arm_cnt <= w_arm_cnt_next;
            if (i_grant && (r_state == FREE)) begin
                r_owner <= i_grant_owner;
                r_dir   <= i_grant_dir;
            end
        end
    end

    // ARM gives the datapath two frames to raise busy before the slot is reclaimed
    always_comb begin
        w_next         = r_state;
        w_arm_cnt_next = 1'b0;
        case (r_state)
            FREE:    if (i_grant) w_next = LAUNCH;
            LAUNCH:  w_next = ARM;
            ARM: begin
                if (i_slot_busy)    w_next = FLIGHT;
                else if (r_arm_cnt) w_next = FREE;
                else                w_arm_cnt_next = 1'b1;
            end
            FLIGHT:  if (!i_slot_busy) w_next = FREE;
            default: w_next = FREE;
        endcase
    end

    always_comb begin
        o_launch = (r_state == LAUNCH);
        o_state  = r_state;
        o_owner  = r_owner;
        o_dir    = r_dir;
    end

endmodule

// File: rtl/bullet_slot_scheduler.sv
// Two-player bullet slot arbiter: edge-detects fire keys, applies cooldown and in-flight limits,
// and hands the lowest free slots to eligible players with a toggling tie-break priority.
module bullet_slot_scheduler
    import bullet_sched_pkg::*;
#(
    parameter int         NUM_SLOTS       = 4,
    parameter int         MAX_PER_PLAYER  = 2,
    parameter int         COOLDOWN_FRAMES = 8,
    parameter logic [7:0] P1_FIRE_KEY     = DEF_P1_FIRE_KEY,
    parameter logic [7:0] P2_FIRE_KEY     = DEF_P2_FIRE_KEY
) (
    input  logic                           frame_clk,
    input  logic                           Reset,
    input  logic [7:0]                     keycode0,
    input  logic [7:0]                     keycode1,
    input  logic [1:0]                     dir1,
    input  logic [1:0]                     dir2,
    input  logic [NUM_SLOTS-1:0]           slot_busy,
    output logic [NUM_SLOTS-1:0]           launch,
    output logic [NUM_SLOTS-1:0]           slot_owner,
    output logic [2*NUM_SLOTS-1:0]         slot_dir,
    output logic [$clog2(NUM_SLOTS+1)-1:0] inflight1,
    output logic [$clog2(NUM_SLOTS+1)-1:0] inflight2,
    output logic                           fire_denied1,
    output logic                           fire_denied2
);

    localparam int CNT_W = $clog2(NUM_SLOTS + 1);
    localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PER_PLAYER);
    localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(COOLDOWN_FRAMES);

    logic             r_prev1, r_prev2;
    logic [CD_W-1:0]  r_cd1, r_cd2;
    logic             r_denied1, r_denied2;
    player_t          r_prio;

    logic                 w_req1, w_req2;
    logic                 w_elig1, w_elig2, w_contest;
    logic                 w_gnt1, w_gnt2;
    logic [NUM_SLOTS-1:0] w_free, w_first_oh, w_second_oh;
    logic                 w_first_found, w_second_found;
    logic [NUM_SLOTS-1:0] w_g1_oh, w_g2_oh, w_grant;
    logic [CNT_W-1:0]     w_inflight1, w_inflight2;

    slot_state_t w_state     [NUM_SLOTS];
    player_t     w_owner     [NUM_SLOTS];
    player_t     w_gnt_owner [NUM_SLOTS];
    dir_t        w_dir       [NUM_SLOTS];
    dir_t        w_gnt_dir   [NUM_SLOTS];

    function automatic logic [CD_W-1:0] cd_next(input logic [CD_W-1:0] cur, input logic load);
        if (load)            return CD_LOAD;
        else if (cur != '0)  return cur - CD_W'(1);
        else                 return '0;
    endfunction

    assign w_req1 = ((keycode0 == P1_FIRE_KEY) || (keycode1 == P1_FIRE_KEY)) && !r_prev1;
    assign w_req2 = ((keycode0 == P2_FIRE_KEY) || (keycode1 == P2_FIRE_KEY)) && !r_prev2;

    always_comb begin
        w_first_oh     = '0;
        w_second_oh    = '0;
        w_first_found  = 1'b0;
        w_second_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_free[i]) begin
                if (!w_first_found) begin
                    w_first_oh[i] = 1'b1;
                    w_first_found = 1'b1;
                end else if (!w_second_found) begin
                    w_second_oh[i] = 1'b1;
                    w_second_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_inflight1 = '0;
        w_inflight2 = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_state[i] != FREE) begin
                if (w_owner[i] == PLAYER2) w_inflight2 = w_inflight2 + CNT_W'(1);
                else                       w_inflight1 = w_inflight1 + CNT_W'(1);
            end
        end
    end

    assign w_elig1 = w_req1 && (r_cd1 == '0) && (w_inflight1 < MAX_CNT) && w_first_found;
    assign w_elig2 = w_req2 && (r_cd2 == '0) && (w_inflight2 < MAX_CNT) && w_first_found;

    // With a single free slot the loser's second pick is empty, which is what denies it
    always_comb begin
        w_g1_oh   = '0;
        w_g2_oh   = '0;
        w_contest = 1'b0;
        if (w_elig1 && w_elig2) begin
            w_contest = 1'b1;
            if (r_prio == PLAYER1) begin
                w_g1_oh = w_first_oh;
                w_g2_oh = w_second_oh;
            end else begin
                w_g2_oh = w_first_oh;
                w_g1_oh = w_second_oh;
            end
        end else if (w_elig1) begin
            w_g1_oh = w_first_oh;
        end else if (w_elig2) begin
            w_g2_oh = w_first_oh;
        end
    end

    assign w_gnt1  = |w_g1_oh;
    assign w_gnt2  = |w_g2_oh;
    assign w_grant = w_g1_oh | w_g2_oh;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_prev1   <= 1'b1;
            r_prev2   <= 1'b1;
            r_cd1     <= '0;
            r_cd2     <= '0;
            r_denied1 <= 1'b0;
            r_denied2 <= 1'b0;
            r_prio    <= PLAYER1;
        end else begin
            r_prev1   <= (keycode0 == P1_FIRE_KEY) || (keycode1 == P1_FIRE_KEY);
            r_prev2   <= (keycode0 == P2_FIRE_KEY) || (keycode1 == P2_FIRE_KEY);
            r_cd1     <= cd_next(r_cd1, w_gnt1);
            r_cd2     <= cd_next(r_cd2, w_gnt2);
            r_denied1 <= w_req1 && !w_gnt1;
            r_denied2 <= w_req2 && !w_gnt2;
            if (w_contest) r_prio <= other_player(r_prio);
        end
    end

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        assign w_gnt_owner[gi] = w_g2_oh[gi] ? PLAYER2 : PLAYER1;
        assign w_gnt_dir[gi]   = w_g2_oh[gi] ? dir_t'(dir2) : dir_t'(dir1);

        bullet_slot_fsm u_fsm (
            .i_clk         (frame_clk),
            .i_rst         (Reset),
            .i_grant       (w_grant[gi]),
            .i_grant_owner (w_gnt_owner[gi]),
            .i_grant_dir   (w_gnt_dir[gi]),
            .i_slot_busy   (slot_busy[gi]),
            .o_launch      (launch[gi]),
            .o_state       (w_state[gi]),
            .o_owner       (w_owner[gi]),
            .o_dir         (w_dir[gi])
        );

        assign w_free[gi]          = (w_state[gi] == FREE);
        assign slot_owner[gi]      = w_owner[gi];
        assign slot_dir[2*gi +: 2] = w_dir[gi];
    end

    assign inflight1    = w_inflight1;
    assign inflight2    = w_inflight2;
    assign fire_denied1 = r_denied1;
    assign fire_denied2 = r_denied2;

endmodule

// File: tb/tb_bullet_slot_scheduler.sv
// Bench for bullet_slot_scheduler: default instance plus a MAX_PER_PLAYER=3, COOLDOWN_FRAMES=2
// instance, which is the only way to reach a contested single free slot with four slots.
module tb_bullet_slot_scheduler;
    import bullet_sched_pkg::*;

    localparam int NS = 4;
    localparam int CW = $clog2(NS + 1);

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;
    logic [7:0]      keycode0, keycode1, kb0, kb1;
    logic [1:0]      dir1, dir2;
    logic [NS-1:0]   slot_busy, busy_b;
    logic [NS-1:0]   launch, slot_owner, launch_b, owner_b;
    logic [2*NS-1:0] slot_dir, dir_b;
    logic [CW-1:0]   if1, if2, if1_b, if2_b;
    logic            den1, den2, den1_b, den2_b;

    always #5 frame_clk = ~frame_clk;

    bullet_slot_scheduler u_dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode0(keycode0), .keycode1(keycode1),
        .dir1(dir1), .dir2(dir2), .slot_busy(slot_busy), .launch(launch),
        .slot_owner(slot_owner), .slot_dir(slot_dir), .inflight1(if1), .inflight2(if2),
        .fire_denied1(den1), .fire_denied2(den2)
    );

    bullet_slot_scheduler #(.NUM_SLOTS(NS), .MAX_PER_PLAYER(3), .COOLDOWN_FRAMES(2)) u_dut_b (
        .frame_clk(frame_clk), .Reset(Reset), .keycode0(kb0), .keycode1(kb1),
        .dir1(dir1), .dir2(dir2), .slot_busy(busy_b), .launch(launch_b),
        .slot_owner(owner_b), .slot_dir(dir_b), .inflight1(if1_b), .inflight2(if2_b),
        .fire_denied1(den1_b), .fire_denied2(den2_b)
    );

    typedef struct {
        int            rep;
        logic [7:0]    k0;
        logic [7:0]    k1;
        logic [NS-1:0] busy;
        logic [NS-1:0] l;
        logic          d1;
        logic          d2;
        logic [CW-1:0] i1;
        logic [CW-1:0] i2;
    } vec_t;

    typedef struct {
        logic [NS-1:0] l;
        logic          d1;
        logic          d2;
        logic [CW-1:0] i1;
        logic [CW-1:0] i2;
        bit            b;
        int            tag;
    } exp_t;

    exp_t sb[$];
    vec_t va[19];
    vec_t vb[9];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input int rep, input logic [7:0] k0, input logic [7:0] k1,
                                input logic [NS-1:0] busy, input logic [NS-1:0] l,
                                input logic d1, input logic d2,
                                input logic [CW-1:0] i1, input logic [CW-1:0] i2);
        vec_t v;
        v.rep = rep; v.k0 = k0; v.k1 = k1; v.busy = busy; v.l = l;
        v.d1 = d1; v.d2 = d2; v.i1 = i1; v.i2 = i2;
        return v;
    endfunction

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %0h, required %0h", nm, tag, act, req);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit on_b, input int idx);
        exp_t e;
        for (int r = 0; r < v.rep; r++) begin
            if (on_b) begin kb0 = v.k0; kb1 = v.k1; busy_b = v.busy; end
            else begin keycode0 = v.k0; keycode1 = v.k1; slot_busy = v.busy; end
            e.l = v.l; e.d1 = v.d1; e.d2 = v.d2; e.i1 = v.i1; e.i2 = v.i2;
            e.b = on_b; e.tag = idx * 100 + r;
            sb.push_back(e);
            @(posedge frame_clk);
            #1;
            e = sb.pop_front();
            if (e.b) begin
                chk("b.launch",       e.tag, 32'(launch_b), 32'(e.l));
                chk("b.fire_denied1", e.tag, 32'(den1_b),   32'(e.d1));
                chk("b.fire_denied2", e.tag, 32'(den2_b),   32'(e.d2));
                chk("b.inflight1",    e.tag, 32'(if1_b),    32'(e.i1));
                chk("b.inflight2",    e.tag, 32'(if2_b),    32'(e.i2));
            end else begin
                chk("launch",       e.tag, 32'(launch), 32'(e.l));
                chk("fire_denied1", e.tag, 32'(den1),   32'(e.d1));
                chk("fire_denied2", e.tag, 32'(den2),   32'(e.d2));
                chk("inflight1",    e.tag, 32'(if1),    32'(e.i1));
                chk("inflight2",    e.tag, 32'(if2),    32'(e.i2));
            end
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, ".launch"},     -1, 32'(launch),     32'(0));
        chk({nm, ".slot_owner"}, -1, 32'(slot_owner), 32'(0));
        chk({nm, ".slot_dir"},   -1, 32'(slot_dir),   32'(0));
        chk({nm, ".inflight1"},  -1, 32'(if1),        32'(0));
        chk({nm, ".inflight2"},  -1, 32'(if2),        32'(0));
        chk({nm, ".denied"},     -1, 32'({den1, den2}), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Default instance: held key, failed launch, cooldown, in-flight limit, simultaneous press
        va[0]  = mk(1, 8'd44, 8'd0,  4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 3'd0);
        va[1]  = mk(1, 8'd44, 8'd0,  4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 3'd0);
        va[2]  = mk(1, 8'd0,  8'd0,  4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 3'd0);
        va[3]  = mk(1, 8'd44, 8'd0,  4'b0000, 4'b0001, 1'b0, 1'b0, 3'd1, 3'd0);
        va[4]  = mk(1, 8'd0,  8'd0,  4'b0000, 4'b0000, 1'b0, 1'b0, 3'd1, 3'd0);
        va[5]  = mk(1, 8'd0,  8'd0,  4'b0000, 4'b0000, 1'b0, 1'b0, 3'd1, 3'd0);
        va[6]  = mk(1, 8'd44, 8'd0,  4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0, 3'd0);
        va[7]  = mk(5, 8'd0,  8'd0,  4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 3'd0);
        va[8]  = mk(1, 8'd44, 8'd0,  4'b0000, 4'b0001, 1'b0, 1'b0, 3'd1, 3'd0);
        va[9]  = mk(8, 8'd0,  8'd0,  4'b0001, 4'b0000, 1'b0, 1'b0, 3'd1, 3'd0);
        va[10] = mk(1, 8'd44, 8'd0,  4'b0001, 4'b0010, 1'b0, 1'b0, 3'd2, 3'd0);
        va[11] = mk(8, 8'd0,  8'd0,  4'b0011, 4'b0000, 1'b0, 1'b0, 3'd2, 3'd0);
        va[12] = mk(1, 8'd44, 8'd0,  4'b0011, 4'b0000, 1'b1, 1'b0, 3'd2, 3'd0);
        va[13] = mk(1, 8'd0,  8'd0,  4'b0011, 4'b0000, 1'b0, 1'b0, 3'd2, 3'd0);
        va[14] = mk(1, 8'd0,  8'd0,  4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 3'd0);
        va[15] = mk(1, 8'd44, 8'd88, 4'b0000, 4'b0011, 1'b0, 1'b0, 3'd1, 3'd1);
        va[16] = mk(2, 8'd0,  8'd0,  4'b0011, 4'b0000, 1'b0, 1'b0, 3'd1, 3'd1);
        va[17] = mk(1, 8'd0,  8'd0,  4'b0011, 4'b0000, 1'b0, 1'b0, 3'd0, 3'd0);
        va[18] = mk(1, 8'd44, 8'd0,  4'b0011, 4'b0001, 1'b0, 1'b0, 3'd1, 3'd0);
        // Second instance: contested single free slot and priority toggling
        vb[0] = mk(1, 8'd44, 8'd88, 4'b0000, 4'b0011, 1'b0, 1'b0, 3'd1, 3'd1);
        vb[1] = mk(2, 8'd0,  8'd0,  4'b0011, 4'b0000, 1'b0, 1'b0, 3'd1, 3'd1);
        vb[2] = mk(1, 8'd44, 8'd0,  4'b0011, 4'b0100, 1'b0, 1'b0, 3'd2, 3'd1);
        vb[3] = mk(2, 8'd0,  8'd0,  4'b0111, 4'b0000, 1'b0, 1'b0, 3'd2, 3'd1);
        vb[4] = mk(1, 8'd44, 8'd88, 4'b0111, 4'b1000, 1'b1, 1'b0, 3'd2, 3'd2);
        vb[5] = mk(2, 8'd0,  8'd0,  4'b1111, 4'b0000, 1'b0, 1'b0, 3'd2, 3'd2);
        vb[6] = mk(1, 8'd44, 8'd0,  4'b0011, 4'b0000, 1'b1, 1'b0, 3'd1, 3'd1);
        vb[7] = mk(1, 8'd0,  8'd0,  4'b0011, 4'b0000, 1'b0, 1'b0, 3'd1, 3'd1);
        vb[8] = mk(1, 8'd44, 8'd88, 4'b0011, 4'b1100, 1'b0, 1'b0, 3'd2, 3'd2);

        keycode0 = 8'd44; keycode1 = 8'd0; kb0 = 8'd0; kb1 = 8'd0;
        dir1 = 2'b10; dir2 = 2'b01; slot_busy = '0; busy_b = '0;
        Reset = 1'b1;
        repeat (2) @(posedge frame_clk);
        #1;
        chk_reset_outputs("reset");
        #3 Reset = 1'b0;

        for (int i = 0; i <= 3; i++) run_vec(va[i], 1'b0, i);
        chk("owner0_after_first", -1, 32'(slot_owner[0]), 32'(0));
        chk("dir0_after_first",   -1, 32'(slot_dir[1:0]), 32'(2'b10));
        for (int i = 4; i <= 15; i++) run_vec(va[i], 1'b0, i);
        chk("owner_simul",  -1, 32'(slot_owner[1:0]), 32'(2'b10));
        chk("dir_simul",    -1, 32'(slot_dir[3:0]),   32'(4'b0110));
        run_vec(va[16], 1'b0, 16);

        run_vec(vb[0], 1'b1, 100);
        chk("b.owner_simul", -1, 32'(owner_b[1:0]), 32'(2'b10));
        chk("b.dir_simul",   -1, 32'(dir_b[3:0]),   32'(4'b0110));
        for (int i = 1; i <= 4; i++) run_vec(vb[i], 1'b1, 100 + i);
        chk("b.owner3_contested", -1, 32'(owner_b[3]),  32'(1));
        chk("b.dir3_contested",   -1, 32'(dir_b[7:6]),  32'(2'b01));
        for (int i = 5; i <= 8; i++) run_vec(vb[i], 1'b1, 100 + i);
        chk("b.owner_after_toggle", -1, 32'(owner_b[3:2]), 32'(2'b10));

        // Two slots in FLIGHT with busy high: reset must clear them without waiting for an edge
        #2 Reset = 1'b1;
        #1;
        chk_reset_outputs("midflight_reset");
        #2 Reset = 1'b0;
        run_vec(va[17], 1'b0, 17);
        run_vec(va[18], 1'b0, 18);
        chk("owner0_post_reset", -1, 32'(slot_owner[0]), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
